// File: rtl/cla_pkg.sv
// cla_pkg: shared state encoding, widths and carry-lookahead span helper for cla_accum_16
package cla_pkg;
  localparam int ACC_W = 16;
  localparam int BYTE_W = 8;
  typedef enum logic [1:0] {IDLE, ADD_LO, ADD_HI, DONE} accum_state_t;
  function automatic logic [BYTE_W-1:0] span_mask(input int lo, input int hi);
    for (int k = 0; k < BYTE_W; k++) span_mask[k] = k >= lo && k < hi;
  endfunction
endpackage

// File: rtl/cla_8bit.sv
// cla_8bit: 8-bit carry-lookahead adder with carry out in Sum[8]
module cla_8bit
  import cla_pkg::*;
(
  input  logic [7:0] A,
  input  logic [7:0] B,
  output logic [8:0] Sum
);
  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;
  assign g = A & B;
  assign p = A ^ B;
  // every carry is the OR of each lower generate whose propagate chain reaches it
  always_comb begin
    c = '0;
    for (int i = 1; i <= 8; i++)
      for (int j = 0; j < i; j++)
        c[i] = c[i] | (g[j] & (&(p | ~span_mask(j + 1, i))));
  end
  assign Sum = {c[8], p ^ c[7:0]};
endmodule

// File: rtl/cla_accum_16.sv
// cla_accum_16: byte-stream accumulator on one time-shared 8-bit CLA; define CLA_ACCUM_SAT_EN to saturate instead of wrap
module cla_accum_16
  import cla_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);
  accum_state_t      state;
  logic [ACC_W-1:0]  acc;
  logic [BYTE_W-1:0] op_r;
  logic              last_r;
  logic              carry_r;
  logic              ovf_r;
  logic [CNT_W-1:0]  count;
  logic              hi;
  logic [BYTE_W-1:0] add_a;
  logic [BYTE_W-1:0] add_b;
  logic [BYTE_W:0]   sum;
  assign hi = state == ADD_HI;
  assign add_a = hi ? acc[15:8] : acc[7:0];
  assign add_b = hi ? {7'b0, carry_r} : op_r;
  cla_8bit u_add (.A(add_a), .B(add_b), .Sum(sum));
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign out_sum = acc;
  assign out_count = count;
  assign out_ovf = ovf_r;
  // accept an operand, add low byte then high byte, hold the result until it is taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc <= '0;
      op_r <= '0;
      last_r <= 1'b0;
      carry_r <= 1'b0;
      ovf_r <= 1'b0;
      count <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_r <= in_data;
          last_r <= in_last;
          state <= ADD_LO;
        end
        ADD_LO: begin
`ifdef CLA_ACCUM_SAT_EN
          if (!ovf_r) acc[7:0] <= sum[7:0];
`else
          acc[7:0] <= sum[7:0];
`endif
          carry_r <= sum[8];
          state <= ADD_HI;
        end
        ADD_HI: begin
`ifdef CLA_ACCUM_SAT_EN
          acc <= (sum[8] || ovf_r) ? '1 : {sum[7:0], acc[7:0]};
`else
          acc[15:8] <= sum[7:0];
`endif
          ovf_r <= ovf_r | sum[8];
          count <= &count ? count : count + 1'b1;
          state <= last_r ? DONE : IDLE;
        end
        default: if (out_ready) begin
          acc <= '0;
          count <= '0;
          ovf_r <= 1'b0;
          carry_r <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cla_accum_16.sv
// tb_cla_accum_16: randomized self-checking bench for cla_accum_16 against an arithmetic stream model
module tb_cla_accum_16;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_sum;
  logic [7:0]  out_count;
  logic        out_ovf;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cla_accum_16 dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf)
  );

  function automatic logic [15:0] model_sum(input int total);
`ifdef CLA_ACCUM_SAT_EN
    return total > 65535 ? 16'hFFFF : 16'(total);
`else
    return 16'(total);
`endif
  endfunction

  function automatic logic [7:0] model_count(input int n);
    return n > 255 ? 8'd255 : 8'(n);
  endfunction

  // hands one operand over; with rnd, inserts gaps and drives junk while in_ready is low
  task automatic send(input logic [7:0] d, input logic l, input bit rnd);
    bit ok = 0;
    for (int n = 0; n < 64 && !ok; n++) begin
      @(negedge clk);
      if (in_ready && (!rnd || $urandom_range(0, 2) != 0)) begin
        in_valid = 1'b1;
        in_data = d;
        in_last = l;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        ok = 1;
      end else begin
        in_valid = (rnd && !in_ready) ? 1'($urandom) : 1'b0;
        in_data = 8'($urandom);
        in_last = 1'($urandom);
      end
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL send: in_ready never rose within 64 cycles (got 0, need 1)");
    end
  endtask

  // takes one result; with rnd, out_ready toggles randomly
  task automatic get_result(input bit rnd, output logic [15:0] s, output logic [7:0] c, output logic o);
    bit ok = 0;
    s = 'x;
    c = 'x;
    o = 1'bx;
    for (int n = 0; n < 64 && !ok; n++) begin
      @(negedge clk);
      out_ready = rnd ? 1'($urandom) : 1'b1;
      if (out_valid && out_ready) begin
        s = out_sum;
        c = out_count;
        o = out_ovf;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        ok = 1;
      end
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL get_result: no out_valid transfer within 64 cycles (got 0, need 1)");
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests++;
    if ({out_valid, out_sum, out_count, out_ovf} !== 26'd0) begin
      fails++;
      $display("FAIL reset_outputs: got valid=%b sum=%h cnt=%0d ovf=%b, need all 0", out_valid, out_sum, out_count, out_ovf);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_ready: got %b, need 1", in_ready);
    end
  endtask

  task automatic test_basic();
    logic [15:0] s; logic [7:0] c; logic o;
    int lat = 1;
    send(8'h10, 1'b0, 0);
    send(8'h20, 1'b0, 0);
    send(8'h30, 1'b1, 0);
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    tests++;
    if (lat != 3) begin
      fails++;
      $display("FAIL basic_latency: got %0d cycles, need 3", lat);
    end
    get_result(0, s, c, o);
    tests++;
    if ({s, c, o} !== {16'h0060, 8'd3, 1'b0}) begin
      fails++;
      $display("FAIL basic_result: got sum=%h cnt=%0d ovf=%b, need 0060 3 0", s, c, o);
    end
  endtask

  task automatic test_carry();
    logic [15:0] s; logic [7:0] c; logic o;
    send(8'hFF, 1'b0, 0);
    send(8'hFF, 1'b1, 0);
    get_result(0, s, c, o);
    tests++;
    if ({s, c, o} !== {16'h01FE, 8'd2, 1'b0}) begin
      fails++;
      $display("FAIL carry_result: got sum=%h cnt=%0d ovf=%b, need 01FE 2 0", s, c, o);
    end
  endtask

  task automatic test_long();
    logic [15:0] s; logic [7:0] c; logic o;
    for (int i = 0; i < 258; i++) send(8'hFF, 1'(i == 257), 0);
    get_result(0, s, c, o);
    tests++;
    if ({s, c, o} !== {model_sum(258 * 255), 8'd255, 1'b1}) begin
      fails++;
      $display("FAIL long_result: got sum=%h cnt=%0d ovf=%b, need %h 255 1", s, c, o, model_sum(258 * 255));
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    out_ready = 1'b0;
    send(8'h07, 1'b1, 0);
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if ({out_valid, out_sum, in_ready} !== {1'b1, 16'h0007, 1'b0}) begin
        fails++;
        $display("FAIL hold_%0d: got valid=%b sum=%h in_ready=%b, need 1 0007 0", i, out_valid, out_sum, in_ready);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    tests++;
    if ({out_valid, in_ready} !== 2'b01) begin
      fails++;
      $display("FAIL hold_release: got valid=%b in_ready=%b, need 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] s; logic [7:0] c; logic o;
    bit seen = 0;
    send(8'h80, 1'b0, 0);
    send(8'h80, 1'b1, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({out_valid, out_sum, out_count, out_ovf} !== 26'd0) begin
      fails++;
      $display("FAIL midreset_outputs: got valid=%b sum=%h cnt=%0d ovf=%b, need all 0", out_valid, out_sum, out_count, out_ovf);
    end
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    out_ready = 1'b0;
    tests++;
    if (seen) begin
      fails++;
      $display("FAIL midreset_no_valid: got out_valid=1 after reset, need 0");
    end
    send(8'h05, 1'b1, 0);
    get_result(0, s, c, o);
    tests++;
    if ({s, c, o} !== {16'h0005, 8'd1, 1'b0}) begin
      fails++;
      $display("FAIL midreset_next: got sum=%h cnt=%0d ovf=%b, need 0005 1 0", s, c, o);
    end
  endtask

  task automatic test_random();
    logic [15:0] s; logic [7:0] c; logic o;
    for (int k = 0; k < 1000; k++) begin
      int len = (k % 100 == 99) ? 300 : $urandom_range(1, 5);
      int total = 0;
      for (int i = 0; i < len; i++) begin
        logic [7:0] d = (len > 5) ? 8'($urandom_range(200, 255)) : 8'($urandom);
        total += d;
        send(d, 1'(i == len - 1), 1);
      end
      get_result(1, s, c, o);
      tests++;
      if ({s, c, o} !== {model_sum(total), model_count(len), 1'(total > 65535)}) begin
        fails++;
        $display("FAIL random_%0d: got sum=%h cnt=%0d ovf=%b, need %h %0d %b", k, s, c, o,
                 model_sum(total), model_count(len), total > 65535);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_long();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cla_accum_16.md
CLA_ACCUM_16 -- requirements
Module: cla_accum_16

Interface
REQ-001 Parameter CNT_W, default 8, sets the operand-count width; the count saturates at 2^CNT_W-1.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  operand available.
REQ-005 in_ready  output  1  block accepts an operand; transfer occurs on in_valid&&in_ready.
REQ-006 in_data  input  8  unsigned operand.
REQ-007 in_last  input  1  marks the final operand of a stream; sampled with in_data.
REQ-008 out_valid  output  1  result available.
REQ-009 out_ready  input  1  consumer accepts the result; transfer occurs on out_valid&&out_ready.
REQ-010 out_sum  output  16  accumulated stream total.
REQ-011 out_count  output  CNT_W  number of operands in the stream, saturating.
REQ-012 out_ovf  output  1  sticky flag; a carry out of bit 15 occurred during the stream.

Function
REQ-013 The FSM SHALL have the states IDLE, ADD_LO, ADD_HI and DONE.
REQ-014 IDLE: in_ready=1 and out_valid=0; on transfer, latch in_data into op_r and in_last into last_r, then go to ADD_LO.
REQ-015 ADD_LO: adder inputs are acc[7:0] and op_r; register bits [7:0] to acc[7:0] and bit 8 to carry_r; go to ADD_HI.
REQ-016 ADD_HI: adder inputs are acc[15:8] and {7'b0,carry_r}; register bits [7:0] to acc[15:8]; a set bit 8 sets ovf_r.
REQ-017 ADD_HI also increments the count (saturating), then goes to DONE if last_r=1, else to IDLE.
REQ-018 in_ready SHALL be 0 in ADD_LO, ADD_HI and DONE, so throughput is 1 operand per 3 cycles.
REQ-019 DONE: out_valid=1, and out_sum, out_count and out_ovf SHALL stay stable until transfer.
REQ-020 On the DONE transfer, clear acc, count, ovf_r and carry_r, then go to IDLE; the next operand is accepted no earlier than the following cycle.
REQ-021 Latency from the last-operand transfer edge to out_valid high SHALL be exactly 3 cycles.
REQ-022 out_sum, out_count and out_ovf SHALL show the live accumulator values in all states; they are meaningful only while out_valid=1.
REQ-023 A single-operand stream (in_last on the first operand) SHALL produce sum=operand and count=1.
REQ-024 in_data and in_last SHALL be ignored whenever in_ready=0.

Reset
REQ-025 While rst_n=0, the state is IDLE and acc, op_r, last_r, carry_r, count and ovf_r are all 0.
REQ-026 During reset, out_valid=0, out_sum=0, out_count=0 and out_ovf=0; in_ready=1 from the first cycle after deassertion.
REQ-027 Reset asserted in any state SHALL discard any partial stream with no output transfer.

Configuration
REQ-028 With CLA_ACCUM_SAT_EN defined, a carry out of bit 15 SHALL force acc to 16'hFFFF and keep it there for the rest of the stream; out_ovf=1.
REQ-029 Without CLA_ACCUM_SAT_EN, acc SHALL wrap modulo 2^16; out_ovf still reports the carry-out.

Structure
REQ-030 Package cla_pkg SHALL hold the FSM state enum (accum_state_t) and the constants ACC_W=16 and BYTE_W=8.
REQ-031 There SHALL be exactly one adder instance: the team's existing 8-bit carry-lookahead adder, cla_8bit (A[7:0], B[7:0], Sum[8:0]).
REQ-032 The adder SHALL be time-shared between ADD_LO and ADD_HI through input muxes; no second adder is allowed.

Verification
REQ-033 Stream 0x10, 0x20, 0x30(last) with out_ready=1 -> out_sum=0x0060, out_count=3, out_ovf=0; out_valid exactly 3 cycles after the third transfer.
REQ-034 Stream 0xFF, 0xFF(last) -> out_sum=0x01FE and out_count=2, proving the byte carry propagates through ADD_HI.
REQ-035 Stream of 258 x 0xFF -> wrap build: out_sum=0x00FE, out_ovf=1, out_count=255; SAT build: out_sum=0xFFFF, out_ovf=1, out_count=255.
REQ-036 Stream 0x07(last) with out_ready=0 for 5 cycles -> out_valid held, out_sum=0x0007 stable, in_ready=0 throughout; one transfer, then in_ready=1.
REQ-037 Assert rst_n=0 during ADD_HI of stream 0x80, 0x80 -> all outputs 0 and no out_valid; a new stream 0x05(last) -> out_sum=0x0005, out_count=1.
REQ-038 Random in_valid/out_ready toggling on 1000 streams -> every out_sum equals the reference-model sum mod 2^16 (or saturated in the SAT build); no operand lost or duplicated.
